w5300_host_bus: RTL and testbench

Host-side bus master for the Wiznet W5300 in direct, 16-bit data-bus mode. It turns single register read/write requests (10-bit address, 16-bit data) from the socket/config controllers into timed CSn/RDn/WRn strobe sequences on the chip pins. It returns the read data and a completion response, and synchronises the chip's INTn pin. It sits between the W5300 register-level controllers and the FPGA pins.

---
 rtl/w5300_host_bus_pkg.sv | 26 ++
 rtl/w5300_host_bus_sync2.sv | 23 ++
 rtl/w5300_host_bus.sv | 162 ++++++++++++++++
 tb/tb_w5300_host_bus.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/w5300_host_bus_pkg.sv
// Shared types and timing defaults for the W5300 direct-bus host interface.
// Cycle counts are derived from the reference clock so a clock change retimes the bus.
package w5300_host_bus_pkg;

   localparam int CLK_REF_MHZ   = 100;
   localparam int CLK_PERIOD_PS = 1_000_000 / CLK_REF_MHZ;

   localparam int T_SETUP_NS    = 10;
   localparam int T_ACCESS_NS   = 65;
   localparam int T_HOLD_NS     = 10;
   localparam int T_RECOVERY_NS = 30;

   function automatic int nsToCycles(input int ns);
      return (ns * 1000 + CLK_PERIOD_PS - 1) / CLK_PERIOD_PS;
   endfunction

   localparam int SETUP_DEF    = nsToCycles(T_SETUP_NS);
   localparam int ACCESS_DEF   = nsToCycles(T_ACCESS_NS);
   localparam int HOLD_DEF     = nsToCycles(T_HOLD_NS);
   localparam int RECOVERY_DEF = nsToCycles(T_RECOVERY_NS);

   typedef enum logic {WR = 1'b0, RD = 1'b1} AddrOperation;

   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, RECOVER, ERR} BusState;

endpackage

// File: rtl/w5300_host_bus_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs; flops reset to RESET_VAL.
module w5300_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/w5300_host_bus.sv
// W5300 direct 16-bit bus master: turns single register requests into timed
// CSn/RDn/WRn strobe sequences and returns read data plus a completion pulse.
module w5300_host_bus
   import w5300_host_bus_pkg::*;
#(
   parameter int SETUP_CYCLES    = SETUP_DEF,
   parameter int ACCESS_CYCLES   = ACCESS_DEF,
   parameter int HOLD_CYCLES     = HOLD_DEF,
   parameter int RECOVERY_CYCLES = RECOVERY_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        reqValid,
   output logic        reqReady,
   input  logic        reqOp,
   input  logic [9:0]  reqAddr,
   input  logic [15:0] reqData,
   output logic        rspValid,
   output logic        rspErr,
   output logic [15:0] rspData,
   output logic [9:0]  addr_o,
   output logic [15:0] data_o,
   input  logic [15:0] data_i,
   output logic        data_oe,
   output logic        cs_n,
   output logic        rd_n,
   output logic        wr_n,
   input  logic        intn_i,
   output logic        irq
);

   localparam int MAX_SA  = (SETUP_CYCLES > ACCESS_CYCLES) ? SETUP_CYCLES : ACCESS_CYCLES;
   localparam int MAX_HR  = (HOLD_CYCLES > RECOVERY_CYCLES) ? HOLD_CYCLES : RECOVERY_CYCLES;
   localparam int MAX_CYC = (MAX_SA > MAX_HR) ? MAX_SA : MAX_HR;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   if (SETUP_CYCLES < 1 || ACCESS_CYCLES < 1 || HOLD_CYCLES < 1 || RECOVERY_CYCLES < 1) begin : gBadParam
      $error("w5300_host_bus: all timing parameters must be >= 1");
   end

   BusState          state, stateNext;
   logic [CNT_W-1:0] cnt, cntNext;
   AddrOperation     op, opNext;
   logic             csNext, rdNext, wrNext, oeNext, rspValidNext, rspErrNext, captureRd;
   logic [9:0]       addrNext;
   logic [15:0]      dataNext;
   logic             cntDone;
   logic             intnSync;

   assign reqReady = (state == IDLE);
   assign cntDone  = (cnt == '0);

   always_comb begin
      stateNext    = state;
      cntNext      = cnt - CNT_W'(1);
      opNext       = op;
      csNext       = cs_n;
      rdNext       = rd_n;
      wrNext       = wr_n;
      oeNext       = data_oe;
      addrNext     = addr_o;
      dataNext     = data_o;
      rspValidNext = 1'b0;
      rspErrNext   = 1'b0;
      captureRd    = 1'b0;
      case (state)
         IDLE: begin
            cntNext = cnt;
            if (reqValid) begin
               opNext = AddrOperation'(reqOp);
               if (reqAddr[0]) begin
                  // Odd address: answer with an error and never touch the pins.
                  stateNext    = ERR;
                  rspValidNext = 1'b1;
                  rspErrNext   = 1'b1;
               end else begin
                  stateNext = SETUP;
                  cntNext   = CNT_W'(SETUP_CYCLES - 1);
                  csNext    = 1'b0;
                  addrNext  = reqAddr;
                  if (AddrOperation'(reqOp) == WR) begin
                     oeNext   = 1'b1;
                     dataNext = reqData;
                  end
               end
            end
         end
         SETUP: if (cntDone) begin
            stateNext = ACCESS;
            cntNext   = CNT_W'(ACCESS_CYCLES - 1);
            rdNext    = (op != RD);
            wrNext    = (op != WR);
         end
         ACCESS: if (cntDone) begin
            stateNext = HOLD;
            cntNext   = CNT_W'(HOLD_CYCLES - 1);
            rdNext    = 1'b1;
            wrNext    = 1'b1;
            captureRd = (op == RD);
         end
         HOLD: if (cntDone) begin
            stateNext    = RECOVER;
            cntNext      = CNT_W'(RECOVERY_CYCLES - 1);
            csNext       = 1'b1;
            oeNext       = 1'b0;
            rspValidNext = 1'b1;
         end
         RECOVER: if (cntDone) begin
            stateNext = IDLE;
            cntNext   = '0;
         end
         ERR: begin
            stateNext = IDLE;
            cntNext   = '0;
         end
         default: begin
            stateNext = IDLE;
            cntNext   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         op       <= WR;
         cs_n     <= 1'b1;
         rd_n     <= 1'b1;
         wr_n     <= 1'b1;
         data_oe  <= 1'b0;
         addr_o   <= '0;
         data_o   <= '0;
         rspValid <= 1'b0;
         rspErr   <= 1'b0;
         rspData  <= '0;
      end else begin
         state    <= stateNext;
         cnt      <= cntNext;
         op       <= opNext;
         cs_n     <= csNext;
         rd_n     <= rdNext;
         wr_n     <= wrNext;
         data_oe  <= oeNext;
         addr_o   <= addrNext;
         data_o   <= dataNext;
         rspValid <= rspValidNext;
         rspErr   <= rspErrNext;
         if (captureRd) rspData <= data_i;
      end
   end

   w5300_sync2 #(.RESET_VAL(1'b1)) uIntnSync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (intn_i),
      .q     (intnSync)
   );

   assign irq = ~intnSync;

endmodule

// File: tb/tb_w5300_host_bus.sv
// Directed bench for w5300_host_bus: write/read timing, odd-address error,
// back-to-back throughput, reset abort and INTn synchronisation.
module tb_w5300_host_bus;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        reqValid;
   logic        reqReady;
   logic        reqOp;
   logic [9:0]  reqAddr;
   logic [15:0] reqData;
   logic        rspValid;
   logic        rspErr;
   logic [15:0] rspData;
   logic [9:0]  addr_o;
   logic [15:0] data_o;
   logic [15:0] data_i;
   logic        data_oe;
   logic        cs_n;
   logic        rd_n;
   logic        wr_n;
   logic        intn_i;
   logic        irq;
   logic [15:0] readVal;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   // Chip model: drives the programmed register value only while RDn is low.
   assign data_i = rd_n ? 16'hDEAD : readVal;

   w5300_host_bus dut (
      .clk(clk), .rst_n(rst_n),
      .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp),
      .reqAddr(reqAddr), .reqData(reqData),
      .rspValid(rspValid), .rspErr(rspErr), .rspData(rspData),
      .addr_o(addr_o), .data_o(data_o), .data_i(data_i), .data_oe(data_oe),
      .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
      .intn_i(intn_i), .irq(irq)
   );

   task automatic test_reset();
      logic [50:0] got, exp;
      rst_n = 1'b0; reqValid = 1'b0; reqOp = 1'b0; reqAddr = '0; reqData = '0;
      intn_i = 1'b1; readVal = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      got = {cs_n, rd_n, wr_n, data_oe, rspValid, rspErr, rspData, addr_o, data_o, irq};
      exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 10'h000, 16'h0000, 1'b0};
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL reset_values got %h exp %h", got, exp);
      end
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (reqReady !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready got %b exp 1", reqReady);
      end
   endtask

   task automatic test_write();
      logic [6:0] got, exp;
      @(negedge clk);
      reqOp = 1'b0; reqAddr = 10'h000; reqData = 16'h0080; reqValid = 1'b1;
      @(posedge clk); #1 reqValid = 1'b0;
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk);
         exp = {!(c >= 1 && c <= 9), 1'b1, !(c >= 2 && c <= 8), (c >= 1 && c <= 9),
                (c == 10), 1'b0, (c >= 13)};
         got = {cs_n, rd_n, wr_n, data_oe, rspValid, rspErr, reqReady};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL write_pins cyc%0d got %b exp %b", c, got, exp);
         end
         if (c == 1 || c == 5 || c == 9) begin
            vectors++;
            if ({addr_o, data_o} !== {10'h000, 16'h0080}) begin
               miscompares++;
               $display("FAIL write_bus cyc%0d got %h/%h exp 000/0080", c, addr_o, data_o);
            end
         end
      end
   endtask

   task automatic test_read(input logic [9:0] addr, input logic [15:0] val);
      logic [6:0] got, exp;
      readVal = val;
      @(negedge clk);
      reqOp = 1'b1; reqAddr = addr; reqData = 16'hFFFF; reqValid = 1'b1;
      @(posedge clk); #1 reqValid = 1'b0;
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk);
         exp = {!(c >= 1 && c <= 9), !(c >= 2 && c <= 8), 1'b1, 1'b0,
                (c == 10), 1'b0, (c >= 13)};
         got = {cs_n, rd_n, wr_n, data_oe, rspValid, rspErr, reqReady};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL read_pins cyc%0d got %b exp %b", c, got, exp);
         end
         if (c == 5) begin
            vectors++;
            if (addr_o !== addr) begin
               miscompares++;
               $display("FAIL read_addr got %h exp %h", addr_o, addr);
            end
         end
         if (c == 10 || c == 13) begin
            vectors++;
            if (rspData !== val) begin
               miscompares++;
               $display("FAIL read_data cyc%0d got %h exp %h", c, rspData, val);
            end
         end
      end
   endtask

   task automatic test_odd_addr();
      logic [4:0] got, exp;
      @(negedge clk);
      reqOp = 1'b0; reqAddr = 10'h209; reqData = 16'h1111; reqValid = 1'b1;
      @(posedge clk); #1 reqValid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         exp = {1'b1, 1'b0, (c == 1), (c == 1), (c >= 2)};
         got = {cs_n, data_oe, rspValid, rspErr, reqReady};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL odd_addr cyc%0d got %b exp %b", c, got, exp);
         end
      end
      vectors++;
      if (rspData !== 16'h5300 || addr_o !== 10'h0fe) begin
         miscompares++;
         $display("FAIL odd_untouched got %h/%h exp 5300/0fe", rspData, addr_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0]  addrs [3];
      logic [15:0] datas [3];
      int acc [3];
      int nAcc = 0, rspCnt = 0, rspRise = 0, hiRun = 0, minHi = 999, viol = 0;
      logic seenLow = 1'b0, prevRsp = 1'b0, acceptNow;
      addrs[0] = 10'h008; addrs[1] = 10'h00a; addrs[2] = 10'h00c;
      datas[0] = 16'h0008; datas[1] = 16'hDC00; datas[2] = 16'h0102;
      acc[0] = -1; acc[1] = -1; acc[2] = -1;
      @(negedge clk);
      reqOp = 1'b0; reqAddr = addrs[0]; reqData = datas[0]; reqValid = 1'b1;
      for (int n = 0; n < 45; n++) begin
         if (rspValid) rspCnt++;
         if (rspValid && !prevRsp) rspRise++;
         prevRsp = rspValid;
         if ((!rd_n && !wr_n) || (data_oe && !rd_n) || (data_oe && cs_n)) viol++;
         if (cs_n) hiRun++;
         else begin
            if (seenLow && hiRun > 0 && hiRun < minHi) minHi = hiRun;
            seenLow = 1'b1;
            hiRun = 0;
         end
         if (nAcc > 0 && n == acc[nAcc-1] + 2) begin
            vectors++;
            if ({addr_o, data_o} !== {addrs[nAcc-1], datas[nAcc-1]}) begin
               miscompares++;
               $display("FAIL b2b_bus req%0d got %h/%h exp %h/%h", nAcc - 1,
                        addr_o, data_o, addrs[nAcc-1], datas[nAcc-1]);
            end
         end
         acceptNow = reqValid && reqReady;
         if (acceptNow && nAcc < 3) begin acc[nAcc] = n; nAcc++; end
         @(posedge clk); #1;
         if (acceptNow) begin
            if (nAcc < 3) begin reqAddr = addrs[nAcc]; reqData = datas[nAcc]; end
            else reqValid = 1'b0;
         end
         @(negedge clk);
      end
      vectors++;
      if (nAcc !== 3 || acc[0] !== 0 || acc[1] !== 13 || acc[2] !== 26) begin
         miscompares++;
         $display("FAIL b2b_accepts got n=%0d %0d,%0d,%0d exp 3 0,13,26", nAcc, acc[0], acc[1], acc[2]);
      end
      vectors++;
      if (rspCnt !== 3 || rspRise !== 3) begin
         miscompares++;
         $display("FAIL b2b_rsp got cycles=%0d pulses=%0d exp 3/3", rspCnt, rspRise);
      end
      vectors++;
      if (minHi < 3) begin
         miscompares++;
         $display("FAIL b2b_recovery got min cs_n high %0d exp >=3", minHi);
      end
      vectors++;
      if (viol !== 0) begin
         miscompares++;
         $display("FAIL strobe_exclusive got %0d violations exp 0", viol);
      end
   endtask

   task automatic test_reset_mid_access();
      logic [47:0] got, exp;
      int bad = 0;
      @(negedge clk);
      reqOp = 1'b0; reqAddr = 10'h010; reqData = 16'hBEEF; reqValid = 1'b1;
      @(posedge clk); #1 reqValid = 1'b0;
      repeat (5) @(negedge clk);
      vectors++;
      if (wr_n !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_precond wr_n got %b exp 0", wr_n);
      end
      rst_n = 1'b0;
      @(negedge clk);
      got = {cs_n, rd_n, wr_n, data_oe, rspValid, rspData, addr_o, data_o};
      exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 10'h000, 16'h0000};
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL abort_pins got %h exp %h", got, exp);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (rspValid || !cs_n) bad++;
      end
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL abort_no_rsp got %0d active cycles exp 0", bad);
      end
      test_read(10'h01e, 16'h1234);
   endtask

   task automatic test_irq();
      @(negedge clk); #3 intn_i = 1'b0;
      @(negedge clk);
      vectors++;
      if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_set_1edge got %b exp 0", irq); end
      @(negedge clk);
      vectors++;
      if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_set got %b exp 1", irq); end
      #3 intn_i = 1'b1;
      @(negedge clk);
      vectors++;
      if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_clr_1edge got %b exp 1", irq); end
      @(negedge clk);
      vectors++;
      if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clr got %b exp 0", irq); end
      #3 intn_i = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      vectors++;
      if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_reset got %b exp 0", irq); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_after_reset got %b exp 1", irq); end
      intn_i = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_write();
      test_read(10'h0fe, 16'h5300);
      test_odd_addr();
      test_back_to_back();
      test_reset_mid_access();
      test_irq();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
